// File: rtl/tone_pkg.sv
// tone_pkg: constants, meter FSM states and note half-periods shared by the tone generator and meter
package tone_pkg;
  localparam int DEF_CNT_W = 19;
  localparam int DEF_TIMEOUT_CYC = 262143;
  localparam int DEF_MIN_HALF = 1000;
  localparam int DEF_LOCK_TOL = 4;
  localparam int HALF_W = 18;
  typedef enum logic [1:0] {IDLE, ARMED, MEAS} meter_state_t;
  // half-period counts at 100 MHz in freqVal encoding
  localparam logic [HALF_W-1:0] NOTE_A4 = 18'd113635;
  localparam logic [HALF_W-1:0] NOTE_B4 = 18'd101237;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-FF synchronizer with a one-cycle pulse on either input transition
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic toggle
);
  logic [2:0] sh_q, sh_d;
  always_comb sh_d = clr ? 3'b000 : {sh_q[1:0], din};
  always_ff @(posedge clk or posedge rst)
    if (rst) sh_q <= '0;
    else sh_q <= sh_d;
  assign toggle = sh_q[1] ^ sh_q[2];
endmodule

// File: rtl/tone_period_meter.sv
// tone_period_meter: measures the half-period of a square-wave input in clock cycles,
// reporting it in the generator's freqVal encoding with lock and silence detection
module tone_period_meter
  import tone_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int MIN_HALF = DEF_MIN_HALF,
  parameter int LOCK_TOL = DEF_LOCK_TOL
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic              audioIn,
  output logic [HALF_W-1:0] halfPeriod,
  output logic              valid,
  output logic              locked,
  output logic              silent
);
  meter_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, last_q, last_d, diff;
  logic [HALF_W-1:0] half_q, half_d;
  logic valid_q, valid_d, locked_q, locked_d;
  logic edge_p, sat, timeout, long_enough;
  sync_edge_detect u_sync (
    .clk(CLK),
    .rst(RST),
    .clr(!enable),
    .din(audioIn),
    .toggle(edge_p)
  );
  always_comb begin
    sat = cnt_q == CNT_W'(TIMEOUT_CYC);
    timeout = sat && state_q != IDLE;
    long_enough = cnt_q >= CNT_W'(MIN_HALF);
    diff = cnt_q >= last_q ? cnt_q - last_q : last_q - cnt_q;
    cnt_d = edge_p ? '0 : sat ? cnt_q : cnt_q + 1'b1;
    state_d = state_q;
    half_d = half_q;
    valid_d = 1'b0;
    locked_d = locked_q;
    last_d = last_q;
    // a coincident edge after timeout becomes the first edge of a new measurement
    if (timeout) begin
      state_d = edge_p ? ARMED : IDLE;
      half_d = '0;
      locked_d = 1'b0;
    end else if (edge_p && state_q == IDLE) state_d = ARMED;
    else if (edge_p && long_enough) begin
      state_d = MEAS;
      half_d = HALF_W'(cnt_q);
      valid_d = 1'b1;
      locked_d = state_q == MEAS && diff <= CNT_W'(LOCK_TOL);
      last_d = cnt_q;
    end else if (edge_p) begin
      state_d = ARMED;
      locked_d = 1'b0;
    end
    if (!enable) begin
      state_d = IDLE;
      cnt_d = '0;
      half_d = '0;
      valid_d = 1'b0;
      locked_d = 1'b0;
      last_d = '0;
    end
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      half_q <= '0;
      valid_q <= 1'b0;
      locked_q <= 1'b0;
      last_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      half_q <= half_d;
      valid_q <= valid_d;
      locked_q <= locked_d;
      last_q <= last_d;
    end
  assign halfPeriod = half_q;
  assign valid = valid_q;
  assign locked = locked_q;
  assign silent = state_q == IDLE;
endmodule

// File: tb/tb_tone_period_meter.sv
// tb_tone_period_meter: randomized and directed checks of the period meter against an interval-rule model
module tb_tone_period_meter;
  localparam int TO = 4000;
  localparam int MINH = 100;
  localparam int TOL = 4;
  localparam int A = 1137;
  localparam int B = 1013;
  logic CLK = 0, RST = 0, enable = 0, audioIn = 0;
  logic [17:0] halfPeriod;
  logic valid, locked, silent;
  int tests = 0, fails = 0, vcnt = 0;
  logic valid_prev = 0;
  bit m_silent = 1, m_ref = 0, m_lock = 0, e_valid = 0;
  int m_hp = 0, m_last = 0;

  tone_period_meter #(.CNT_W(19), .TIMEOUT_CYC(TO), .MIN_HALF(MINH), .LOCK_TOL(TOL)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .audioIn(audioIn),
    .halfPeriod(halfPeriod), .valid(valid), .locked(locked), .silent(silent)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (valid) begin
      tests++;
      vcnt++;
      if (valid_prev) begin
        fails++;
        $display("FAIL valid_pulse_width: valid high two cycles running, want single-cycle pulse");
      end
    end
    valid_prev = valid;
  end

  function automatic void model_reset();
    m_silent = 1; m_ref = 0; m_lock = 0; m_hp = 0;
  endfunction

  // m = cycles between input transitions minus one
  function automatic void model_edge(input int m);
    e_valid = 0;
    if (m_silent) m_silent = 0;
    else if (m >= TO) begin m_ref = 0; m_lock = 0; m_hp = 0; end
    else if (m < MINH) begin m_ref = 0; m_lock = 0; end
    else begin
      e_valid = 1;
      m_lock = m_ref && ((m > m_last ? m - m_last : m_last - m) <= TOL);
      m_hp = m; m_last = m; m_ref = 1;
    end
  endfunction

  task automatic step(input int d, output int nv);
    int v0;
    v0 = vcnt;
    repeat (d - 4) @(negedge CLK);
    audioIn = ~audioIn;
    model_edge(d - 1);
    repeat (4) @(negedge CLK);
    nv = vcnt - v0;
  endtask

  task automatic test_reset();
    RST = 1;
    #2;
    tests += 4;
    if (halfPeriod !== 18'd0) begin fails++; $display("FAIL reset halfPeriod: got %0d want 0", halfPeriod); end
    if (valid !== 1'b0) begin fails++; $display("FAIL reset valid: got %b want 0", valid); end
    if (locked !== 1'b0) begin fails++; $display("FAIL reset locked: got %b want 0", locked); end
    if (silent !== 1'b1) begin fails++; $display("FAIL reset silent: got %b want 1", silent); end
    repeat (2) @(negedge CLK);
    RST = 0;
    enable = 1;
    model_reset();
  endtask

  task automatic test_lock();
    int seq[$] = '{A, A, A};
    int nv;
    foreach (seq[i]) begin
      step(seq[i], nv);
      tests += 4;
      if (nv !== int'(e_valid)) begin fails++; $display("FAIL lock[%0d] valid pulses: got %0d want %0d", i, nv, e_valid); end
      if (halfPeriod !== 18'(m_hp)) begin fails++; $display("FAIL lock[%0d] halfPeriod: got %0d want %0d", i, halfPeriod, m_hp); end
      if (locked !== m_lock) begin fails++; $display("FAIL lock[%0d] locked: got %b want %b", i, locked, m_lock); end
      if (silent !== m_silent) begin fails++; $display("FAIL lock[%0d] silent: got %b want %b", i, silent, m_silent); end
    end
    tests++;
    if (halfPeriod !== 18'd1136 || locked !== 1'b1 || silent !== 1'b0) begin
      fails++; $display("FAIL lock_final: got hp=%0d locked=%b silent=%b want 1136/1/0", halfPeriod, locked, silent);
    end
  endtask

  task automatic test_silence();
    int v0;
    v0 = vcnt;
    repeat (TO - 1) @(negedge CLK);
    tests += 2;
    if (silent !== 1'b0) begin fails++; $display("FAIL silence_early silent: got %b want 0", silent); end
    if (locked !== 1'b1) begin fails++; $display("FAIL silence_early locked: got %b want 1", locked); end
    @(negedge CLK);
    model_reset();
    tests += 4;
    if (silent !== 1'b1) begin fails++; $display("FAIL silence silent: got %b want 1", silent); end
    if (locked !== 1'b0) begin fails++; $display("FAIL silence locked: got %b want 0", locked); end
    if (halfPeriod !== 18'd0) begin fails++; $display("FAIL silence halfPeriod: got %0d want 0", halfPeriod); end
    if (vcnt !== v0) begin fails++; $display("FAIL silence valid pulses: got %0d want 0", vcnt - v0); end
  endtask

  task automatic test_glitch();
    int seq[$] = '{A, A, A, 10, 10, A, A};
    int nv;
    foreach (seq[i]) begin
      step(seq[i], nv);
      tests += 4;
      if (nv !== int'(e_valid)) begin fails++; $display("FAIL glitch[%0d] valid pulses: got %0d want %0d", i, nv, e_valid); end
      if (halfPeriod !== 18'(m_hp)) begin fails++; $display("FAIL glitch[%0d] halfPeriod: got %0d want %0d", i, halfPeriod, m_hp); end
      if (locked !== m_lock) begin fails++; $display("FAIL glitch[%0d] locked: got %b want %b", i, locked, m_lock); end
      if (silent !== m_silent) begin fails++; $display("FAIL glitch[%0d] silent: got %b want %b", i, silent, m_silent); end
      if (i == 4) begin
        tests++;
        if (halfPeriod !== 18'd1136 || locked !== 1'b0) begin
          fails++; $display("FAIL glitch_hold: got hp=%0d locked=%b want 1136/0", halfPeriod, locked);
        end
      end
    end
  endtask

  task automatic test_pitch();
    int seq[$] = '{B, B};
    int nv;
    foreach (seq[i]) begin
      step(seq[i], nv);
      tests += 4;
      if (nv !== int'(e_valid)) begin fails++; $display("FAIL pitch[%0d] valid pulses: got %0d want %0d", i, nv, e_valid); end
      if (halfPeriod !== 18'(m_hp)) begin fails++; $display("FAIL pitch[%0d] halfPeriod: got %0d want %0d", i, halfPeriod, m_hp); end
      if (locked !== m_lock) begin fails++; $display("FAIL pitch[%0d] locked: got %b want %b", i, locked, m_lock); end
      if (silent !== m_silent) begin fails++; $display("FAIL pitch[%0d] silent: got %b want %b", i, silent, m_silent); end
      tests++;
      if (halfPeriod !== 18'd1012 || locked !== (i == 1)) begin
        fails++; $display("FAIL pitch_const[%0d]: got hp=%0d locked=%b want 1012/%0d", i, halfPeriod, locked, i);
      end
    end
  endtask

  task automatic test_tolerance();
    int seq[$] = '{1002, 1005, 1002, 1005, 1002, 1011, 1002, 1011};
    int nv;
    foreach (seq[i]) begin
      step(seq[i], nv);
      tests += 4;
      if (nv !== int'(e_valid)) begin fails++; $display("FAIL tol[%0d] valid pulses: got %0d want %0d", i, nv, e_valid); end
      if (halfPeriod !== 18'(m_hp)) begin fails++; $display("FAIL tol[%0d] halfPeriod: got %0d want %0d", i, halfPeriod, m_hp); end
      if (locked !== m_lock) begin fails++; $display("FAIL tol[%0d] locked: got %b want %b", i, locked, m_lock); end
      if (silent !== m_silent) begin fails++; $display("FAIL tol[%0d] silent: got %b want %b", i, silent, m_silent); end
    end
    tests++;
    if (locked !== 1'b0) begin fails++; $display("FAIL tol_final locked: got %b want 0", locked); end
  endtask

  task automatic test_enable();
    int seq[$] = '{A, A, A};
    int nv;
    repeat (300) @(negedge CLK);
    enable = 0;
    audioIn = 0;
    @(negedge CLK);
    enable = 1;
    model_reset();
    tests += 3;
    if (halfPeriod !== 18'd0) begin fails++; $display("FAIL enable halfPeriod: got %0d want 0", halfPeriod); end
    if (locked !== 1'b0) begin fails++; $display("FAIL enable locked: got %b want 0", locked); end
    if (silent !== 1'b1) begin fails++; $display("FAIL enable silent: got %b want 1", silent); end
    foreach (seq[i]) begin
      step(seq[i], nv);
      tests += 4;
      if (nv !== int'(e_valid)) begin fails++; $display("FAIL enable[%0d] valid pulses: got %0d want %0d", i, nv, e_valid); end
      if (halfPeriod !== 18'(m_hp)) begin fails++; $display("FAIL enable[%0d] halfPeriod: got %0d want %0d", i, halfPeriod, m_hp); end
      if (locked !== m_lock) begin fails++; $display("FAIL enable[%0d] locked: got %b want %b", i, locked, m_lock); end
      if (silent !== m_silent) begin fails++; $display("FAIL enable[%0d] silent: got %b want %b", i, silent, m_silent); end
    end
  endtask

  task automatic test_async_reset();
    repeat (200) @(negedge CLK);
    #2 RST = 1;
    #1;
    tests += 3;
    if (halfPeriod !== 18'd0) begin fails++; $display("FAIL async_rst halfPeriod: got %0d want 0", halfPeriod); end
    if (locked !== 1'b0) begin fails++; $display("FAIL async_rst locked: got %b want 0", locked); end
    if (silent !== 1'b1) begin fails++; $display("FAIL async_rst silent: got %b want 1", silent); end
    @(negedge CLK);
    audioIn = 0;
    repeat (2) @(negedge CLK);
    RST = 0;
    model_reset();
  endtask

  task automatic test_random();
    int nv, d, r;
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      d = r == 0 ? $urandom_range(5, MINH) :
          r == 1 ? TO + 1 + $urandom_range(0, 1) * $urandom_range(1, 20) :
          r == 2 ? MINH + $urandom_range(0, 1) :
          r <= 5 ? 600 + $urandom_range(0, 2 * TOL) : $urandom_range(200, 800);
      step(d, nv);
      tests += 4;
      if (nv !== int'(e_valid)) begin fails++; $display("FAIL rand[%0d] d=%0d valid pulses: got %0d want %0d", i, d, nv, e_valid); end
      if (halfPeriod !== 18'(m_hp)) begin fails++; $display("FAIL rand[%0d] d=%0d halfPeriod: got %0d want %0d", i, d, halfPeriod, m_hp); end
      if (locked !== m_lock) begin fails++; $display("FAIL rand[%0d] d=%0d locked: got %b want %b", i, d, locked, m_lock); end
      if (silent !== m_silent) begin fails++; $display("FAIL rand[%0d] d=%0d silent: got %b want %b", i, d, silent, m_silent); end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_silence();
    test_glitch();
    test_pitch();
    test_tolerance();
    test_enable();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
